// File: rtl/exibe_pkg.sv
// Shared definitions for the sequence playback stage: FSM state
// encoding, default timing constants and width helpers.
package exibe_pkg;

   // Playback FSM states; the encodings are fixed so other blocks of
   // the game can decode them if they ever need to.
   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ACESO   = 2'd1,
      APAGADO = 2'd2,
      FIM     = 2'd3
   } estado_t;

   // Default lit / blank durations, in clock cycles.
   localparam int T_ON_PADRAO  = 500;
   localparam int T_OFF_PADRAO = 250;

   // Larger of two integers, used to size the shared timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to count 0..m-1; never less than one bit so that
   // m=1 still yields a legal vector.
   function automatic int largura_timer(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Signal bundle between the playback stage and its surroundings:
// game FSM control, sequence memory read port and LED/mux outputs.
interface exibe_sequencia_if #(
   parameter int N_ADDR = 4,
   parameter int W_DATA = 4
);

   logic              iniciar;
   logic [N_ADDR-1:0] limite;
   logic [W_DATA-1:0] dado_mem;
   logic [N_ADDR-1:0] endereco;
   logic [W_DATA-1:0] leds;
   logic              sel_mux;
   logic              ocupado;
   logic              pronto;

   // Game side: requests playback, supplies memory data, watches status.
   modport master (
      output iniciar, limite, dado_mem,
      input  endereco, leds, sel_mux, ocupado, pronto
   );

   // Playback stage side.
   modport slave (
      input  iniciar, limite, dado_mem,
      output endereco, leds, sel_mux, ocupado, pronto
   );

endinterface

// File: rtl/contador_m.sv
// Parameterised modulo-M counter with synchronous clear. Q runs
// 0..M-1 while conta is high and wraps to 0; fim flags Q==M-1.
module contador_m
   import exibe_pkg::*;
#(
   parameter int M = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         zera,
   input  logic                         conta,
   output logic [largura_timer(M)-1:0]  Q,
   output logic                         fim
);

   localparam int W = largura_timer(M);

   assign fim = (Q == W'(M - 1));

   // Count register: reset and zera clear, conta advances with wrap.
   always_ff @(posedge clock) begin
      // NOTE: state is updated with <= so every register samples the
      // pre-edge values, independent of statement order.
      if (!reset || zera) begin
         Q <= '0;
      end else if (conta) begin
         Q <= fim ? '0 : Q + 1'b1;
      end
   end

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence playback stage for the Memory Challenge game. On a start
// request it shows memory entries 0..limite on the LEDs, each lit for
// T_ON cycles followed by a T_OFF-cycle blank, owns the LED mux while
// doing so, and pulses pronto for one cycle when it is done.
module exibe_sequencia
   import exibe_pkg::*;
#(
   parameter int N_ADDR = 4,
   parameter int W_DATA = 4,
   parameter int T_ON   = T_ON_PADRAO,
   parameter int T_OFF  = T_OFF_PADRAO
) (
   input  logic              clock,
   input  logic              reset,
   exibe_sequencia_if.slave  bus
);

   // One timer serves both phases; it is sized for the longer one and
   // each phase compares against its own terminal value.
   localparam int T_MAX = max_int(T_ON, T_OFF);
   localparam int TW    = largura_timer(T_MAX);

   estado_t           estado;
   estado_t           prox;
   logic [N_ADDR-1:0] endereco;
   logic [N_ADDR-1:0] limite_reg;
   logic [TW-1:0]     timer;
   logic              timer_fim;
   logic              zera;
   logic              conta;
   logic              fim_aceso;
   logic              fim_apagado;
   logic              ultimo;

   // Terminal-count detection per phase. When a phase is the longer
   // one, the counter's own wrap flag marks its last cycle.
   assign fim_aceso   = (T_ON  == T_MAX) ? timer_fim : (timer == TW'(T_ON  - 1));
   assign fim_apagado = (T_OFF == T_MAX) ? timer_fim : (timer == TW'(T_OFF - 1));

   // The address is compared before any increment, so the last entry
   // of a full-size sequence never wraps back to 0.
   assign ultimo = (endereco == limite_reg);

   // Timer runs only while an entry is lit or blanked, and restarts at
   // 0 at every phase boundary and whenever playback is not active.
   assign conta = (estado == ACESO) || (estado == APAGADO);
   assign zera  = (estado == OCIOSO) || (estado == FIM) ||
                  ((estado == ACESO)   && fim_aceso) ||
                  ((estado == APAGADO) && fim_apagado);

   contador_m #(
      .M (T_MAX)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta),
      .Q     (timer),
      .fim   (timer_fim)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox;
      end
   end

   // Next-state logic; start requests are honoured only when idle.
   always_comb begin
      // NOTE: prox gets a default before the case so every path assigns
      // it and no latch is inferred.
      prox = estado;
      unique case (estado)
         OCIOSO:  if (bus.iniciar) prox = ACESO;
         ACESO:   if (fim_aceso)   prox = APAGADO;
         APAGADO: if (fim_apagado) prox = ultimo ? FIM : ACESO;
         FIM:     prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   // Address and round-limit registers: loaded on start, address steps
   // at the end of each blank that is not the last one, then holds.
   always_ff @(posedge clock) begin
      if (!reset) begin
         endereco   <= '0;
         limite_reg <= '0;
      end else if ((estado == OCIOSO) && bus.iniciar) begin
         endereco   <= '0;
         limite_reg <= bus.limite;
      end else if ((estado == APAGADO) && fim_apagado && !ultimo) begin
         endereco   <= endereco + 1'b1;
      end
   end

   assign bus.endereco = endereco;

   // Moore outputs decoded from the current state only.
   always_comb begin
      bus.leds    = '0;
      bus.sel_mux = 1'b0;
      bus.ocupado = 1'b0;
      bus.pronto  = 1'b0;
      unique case (estado)
         OCIOSO: ;
         ACESO: begin
            bus.leds    = bus.dado_mem;
            bus.sel_mux = 1'b1;
            bus.ocupado = 1'b1;
         end
         APAGADO: begin
            bus.sel_mux = 1'b1;
            bus.ocupado = 1'b1;
         end
         FIM: begin
            bus.ocupado = 1'b1;
            bus.pronto  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia with short timing
// (T_ON=4, T_OFF=2). Expected per-cycle outputs come from a model that
// lays out a whole playback as a list of cycles.
module tb_exibe_sequencia;

   localparam int N_ADDR = 4;
   localparam int W_DATA = 4;
   localparam int T_ON   = 4;
   localparam int T_OFF  = 2;

   // Observed vector layout: {leds[3:0], sel_mux, ocupado, pronto, endereco[3:0]}
   typedef logic [10:0] vec_t;

   logic clock = 1'b0;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t exp_q[$];

   exibe_sequencia_if #(.N_ADDR(N_ADDR), .W_DATA(W_DATA)) bus ();

   exibe_sequencia #(
      .N_ADDR (N_ADDR),
      .W_DATA (W_DATA),
      .T_ON   (T_ON),
      .T_OFF  (T_OFF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Sequence memory: a one-hot pattern by address.
   assign bus.dado_mem = 4'b0001 << bus.endereco[1:0];

   function automatic logic [3:0] mem_value(input int addr);
      logic [3:0] one = 4'b0001;
      return one << (addr % 4);
   endfunction

   function automatic vec_t pack(input logic [3:0] l, input logic s,
                                 input logic o, input logic p, input int a);
      logic [3:0] a4 = 4'(a);
      return {l, s, o, p, a4};
   endfunction

   function automatic vec_t observed();
      return {bus.leds, bus.sel_mux, bus.ocupado, bus.pronto, bus.endereco};
   endfunction

   // Whole playback for a given limit, one entry per cycle starting at
   // the first cycle after the start request is sampled.
   task automatic build_expected(input int lim);
      exp_q.delete();
      for (int e = 0; e <= lim; e++) begin
         for (int c = 0; c < T_ON;  c++) exp_q.push_back(pack(mem_value(e), 1'b1, 1'b1, 1'b0, e));
         for (int c = 0; c < T_OFF; c++) exp_q.push_back(pack(4'd0, 1'b1, 1'b1, 1'b0, e));
      end
      exp_q.push_back(pack(4'd0, 1'b0, 1'b1, 1'b1, lim));
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Requests a playback; on return the bench is in its first cycle.
   task automatic start_run(input int lim);
      bus.limite  = 4'(lim);
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
   endtask

   task automatic test_reset();
      vec_t z;
      reset = 1'b0;
      bus.iniciar = 1'b0;
      bus.limite  = '0;
      tick();
      tick();
      z = pack(4'd0, 1'b0, 1'b0, 1'b0, 0);
      if (observed() !== z) begin
         n_fail++;
         $display("FAIL reset_state got %b expected %b", observed(), z);
      end
      n_checks++;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (observed() !== z) begin
            n_fail++;
            $display("FAIL idle_after_reset cyc%0d got %b expected %b", i, observed(), z);
         end
         n_checks++;
      end
   endtask

   task automatic test_playback(input int lim);
      int pronto_seen = 0;
      vec_t idle;
      build_expected(lim);
      start_run(lim);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (observed() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL playback_lim%0d cyc%0d got %b expected %b", lim, i, observed(), exp_q[i]);
         end
         n_checks++;
         if (bus.ocupado === 1'b1) pronto_seen += (bus.pronto === 1'b1) ? 1 : 0;
         tick();
      end
      idle = pack(4'd0, 1'b0, 1'b0, 1'b0, lim);
      if (observed() !== idle) begin
         n_fail++;
         $display("FAIL playback_lim%0d_idle got %b expected %b", lim, observed(), idle);
      end
      n_checks++;
      if (pronto_seen !== 1) begin
         n_fail++;
         $display("FAIL playback_lim%0d_pronto_count got %0d expected 1", lim, pronto_seen);
      end
      n_checks++;
   endtask

   // Start requests and limit changes during a run must be ignored.
   task automatic test_ignore(input int lim, input int new_lim, input bit random_pokes);
      vec_t idle;
      int pronto_seen = 0;
      build_expected(lim);
      start_run(lim);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (observed() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ignore_lim%0d cyc%0d got %b expected %b", lim, i, observed(), exp_q[i]);
         end
         n_checks++;
         if (bus.pronto === 1'b1) pronto_seen++;
         if (i == 1) bus.limite = 4'(new_lim);
         if (random_pokes) bus.iniciar = ($urandom_range(0, 3) == 0);
         else              bus.iniciar = (i == 3 || i == 5 || i == exp_q.size() - 1);
         tick();
      end
      bus.iniciar = 1'b0;
      idle = pack(4'd0, 1'b0, 1'b0, 1'b0, lim);
      if (observed() !== idle) begin
         n_fail++;
         $display("FAIL ignore_lim%0d_idle got %b expected %b", lim, observed(), idle);
      end
      n_checks++;
      if (pronto_seen !== 1) begin
         n_fail++;
         $display("FAIL ignore_lim%0d_pronto_count got %0d expected 1", lim, pronto_seen);
      end
      n_checks++;
      tick();
   endtask

   task automatic test_reset_mid();
      vec_t z;
      build_expected(2);
      start_run(2);
      // Cycle 8 is the 3rd lit cycle of entry 1.
      for (int i = 0; i <= 8; i++) begin
         if (observed() !== exp_q[i]) begin
            n_fail++;
            $display("FAIL reset_mid_pre cyc%0d got %b expected %b", i, observed(), exp_q[i]);
         end
         n_checks++;
         if (i == 8) reset = 1'b0;
         tick();
      end
      z = pack(4'd0, 1'b0, 1'b0, 1'b0, 0);
      if (observed() !== z) begin
         n_fail++;
         $display("FAIL reset_mid_clean got %b expected %b", observed(), z);
      end
      n_checks++;
      reset = 1'b1;
      tick();
      if (observed() !== z) begin
         n_fail++;
         $display("FAIL reset_mid_idle got %b expected %b", observed(), z);
      end
      n_checks++;
      test_playback(1);
   endtask

   // iniciar held high: two runs separated by exactly one idle cycle.
   task automatic test_back_to_back();
      vec_t idle;
      build_expected(1);
      bus.limite  = 4'd1;
      bus.iniciar = 1'b1;
      tick();
      for (int run = 0; run < 2; run++) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (observed() !== exp_q[i]) begin
               n_fail++;
               $display("FAIL back_to_back run%0d cyc%0d got %b expected %b", run, i, observed(), exp_q[i]);
            end
            n_checks++;
            if (run == 1) bus.iniciar = 1'b0;
            tick();
         end
         idle = pack(4'd0, 1'b0, 1'b0, 1'b0, 1);
         if (observed() !== idle) begin
            n_fail++;
            $display("FAIL back_to_back run%0d_gap got %b expected %b", run, observed(), idle);
         end
         n_checks++;
         tick();
      end
      if (observed() !== idle) begin
         n_fail++;
         $display("FAIL back_to_back_stop got %b expected %b", observed(), idle);
      end
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_playback(0);
      test_playback(2);
      test_playback(15);
      test_reset_mid();
      test_ignore(2, 5, 1'b0);
      for (int r = 0; r < 4; r++) begin
         test_ignore($urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
      end
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
